// File: rtl/digit_scan_scheduler.sv
// digit_scan_scheduler
// Sequences the four-digit multiplexed hours/minutes display. A slot counter
// divides each digit slot into a dead-time window, a PWM on-window and an off
// tail. A digit counter walks digits 0..3, and a frame counter drives the
// time-set blink. Configuration inputs are captured into shadow registers only
// while the scan is disabled or at a frame boundary, so a frame always renders
// with one consistent configuration. All outputs come straight from registers.

// Runtime checks for the scan outputs, kept apart from the datapath.
module digit_scan_scheduler_chk (
    input logic       clk,
    input logic       reset,
    input logic [3:0] anode,
    input logic       frame_tick
);

    // Two digits may never be driven at once; that would short segment lines.
    a_anode_onehot0 : assert property (
        @(posedge clk) disable iff (!reset) $onehot0(anode)
    );

    // The frame marker is a single-cycle pulse.
    a_frame_tick_pulse : assert property (
        @(posedge clk) disable iff (!reset) frame_tick |=> !frame_tick
    );

endmodule

module digit_scan_scheduler #(
    parameter int REFRESH_DIV  = 50000,
    parameter int DEAD_CYCLES  = 2,
    parameter int BLINK_FRAMES = 128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] brightness,
    input  logic [3:0] blank_mask,
    input  logic [1:0] blink_sel,
    input  logic       lz_blank,
    input  logic       hr_msb_zero,
    output logic [1:0] digit_sel,
    output logic [3:0] anode,
    output logic       frame_tick,
    output logic       blink_phase
);

    // The slot counter and on-time share one width that holds REFRESH_DIV
    // itself, so brightness 15 (on-time = REFRESH_DIV) needs no saturation.
    localparam int CW = $clog2(REFRESH_DIV) + 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] ON_STEP    = CW'(REFRESH_DIV / 16);
    localparam logic [CW-1:0] DEAD_LIMIT = CW'(DEAD_CYCLES);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [CW-1:0] SLOT_ONE   = CW'(1'b1);
    localparam logic [FW-1:0] FRAME_ONE  = FW'(1'b1);
    localparam logic [3:0]    BRIGHT_RST = 4'd15;

    // Digit k is in the blink group: bit 0 of sel covers the minute digits,
    // bit 1 the hour digits.
    function automatic logic in_blink_group(input logic [1:0] k, input logic [1:0] sel);
        logic hit;
        case (k)
            2'd0, 2'd1: hit = sel[0];
            2'd2, 2'd3: hit = sel[1];
            default:    hit = 1'b0;
        endcase
        return hit;
    endfunction

    // One-hot anode pattern for digit k.
    function automatic logic [3:0] digit_onehot(input logic [1:0] k);
        logic [3:0] oh;
        case (k)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    // PWM on-window end: (level + 1) sixteenths of the slot.
    function automatic logic [CW-1:0] slot_on_time(input logic [3:0] level);
        return (CW'(level) + SLOT_ONE) * ON_STEP;
    endfunction

    // Scan counters
    logic [CW-1:0] slot_cnt_r;
    logic [1:0]    digit_cnt_r;
    logic [FW-1:0] frame_cnt_r;
    logic          blink_phase_r;

    // Shadow configuration, fixed for the duration of a frame
    logic [3:0]    brightness_sh_r;
    logic [3:0]    blank_mask_sh_r;
    logic [1:0]    blink_sel_sh_r;
    logic          lz_blank_sh_r;

    // Output registers
    logic [1:0]    digit_sel_r;
    logic [3:0]    anode_r;
    logic          frame_tick_r;

    // Combinational next-state and qualifiers
    logic          slot_wrap_s;
    logic          frame_wrap_s;
    logic          blink_wrap_s;
    logic          shadow_load_s;
    logic [CW-1:0] slot_nxt_s;
    logic [1:0]    digit_nxt_s;
    logic [FW-1:0] frame_nxt_s;
    logic [CW-1:0] on_time_s;
    logic          in_window_s;
    logic          blinked_s;
    logic          lz_hidden_s;
    logic          digit_dark_s;
    logic [3:0]    anode_nxt_s;
    logic [1:0]    digit_sel_nxt_s;

    // Wrap detection and next values for the slot, digit and frame counters.
    always_comb begin
        slot_wrap_s   = (slot_cnt_r == SLOT_LAST);
        frame_wrap_s  = enable & slot_wrap_s & (digit_cnt_r == 2'd3);
        blink_wrap_s  = frame_wrap_s & (frame_cnt_r == FRAME_LAST);
        shadow_load_s = ~enable | frame_wrap_s;
        slot_nxt_s    = slot_cnt_r;
        digit_nxt_s   = digit_cnt_r;
        frame_nxt_s   = frame_cnt_r;
        if (!enable) begin
            slot_nxt_s  = {CW{1'b0}};
            digit_nxt_s = 2'd0;
            frame_nxt_s = {FW{1'b0}};
        end else if (slot_wrap_s) begin
            slot_nxt_s  = {CW{1'b0}};
            digit_nxt_s = digit_cnt_r + 2'd1;
            if (blink_wrap_s) begin
                frame_nxt_s = {FW{1'b0}};
            end else if (frame_wrap_s) begin
                frame_nxt_s = frame_cnt_r + FRAME_ONE;
            end else begin
                frame_nxt_s = frame_cnt_r;
            end
        end else begin
            slot_nxt_s  = slot_cnt_r + SLOT_ONE;
            digit_nxt_s = digit_cnt_r;
            frame_nxt_s = frame_cnt_r;
        end
    end

    // Decide whether the current digit is lit in this cycle.
    always_comb begin
        on_time_s    = slot_on_time(brightness_sh_r);
        // An on-time at or below the dead time leaves an empty window.
        in_window_s  = (slot_cnt_r >= DEAD_LIMIT) && (slot_cnt_r < on_time_s);
        blinked_s    = blink_phase_r & in_blink_group(digit_cnt_r, blink_sel_sh_r);
        // Hour-tens zero is read live; it cannot change within a frame.
        lz_hidden_s  = (digit_cnt_r == 2'd3) & lz_blank_sh_r & hr_msb_zero;
        digit_dark_s = blank_mask_sh_r[digit_cnt_r] | blinked_s | lz_hidden_s;
        if (enable && in_window_s && !digit_dark_s) begin
            anode_nxt_s = digit_onehot(digit_cnt_r);
        end else begin
            anode_nxt_s = 4'b0000;
        end
        if (enable) begin
            digit_sel_nxt_s = digit_cnt_r;
        end else begin
            digit_sel_nxt_s = 2'd0;
        end
    end

    // Slot, digit and frame counter state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_cnt_r  <= {CW{1'b0}};
            digit_cnt_r <= 2'd0;
            frame_cnt_r <= {FW{1'b0}};
        end else begin
            slot_cnt_r  <= slot_nxt_s;
            digit_cnt_r <= digit_nxt_s;
            frame_cnt_r <= frame_nxt_s;
        end
    end

    // Blink phase flips after every BLINK_FRAMES frames and survives disable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_phase_r <= 1'b0;
        end else if (blink_wrap_s) begin
            blink_phase_r <= ~blink_phase_r;
        end else begin
            blink_phase_r <= blink_phase_r;
        end
    end

    // Capture configuration while idle or at the frame boundary only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            brightness_sh_r <= BRIGHT_RST;
            blank_mask_sh_r <= 4'b0000;
            blink_sel_sh_r  <= 2'b00;
            lz_blank_sh_r   <= 1'b0;
        end else if (shadow_load_s) begin
            brightness_sh_r <= brightness;
            blank_mask_sh_r <= blank_mask;
            blink_sel_sh_r  <= blink_sel;
            lz_blank_sh_r   <= lz_blank;
        end else begin
            brightness_sh_r <= brightness_sh_r;
            blank_mask_sh_r <= blank_mask_sh_r;
            blink_sel_sh_r  <= blink_sel_sh_r;
            lz_blank_sh_r   <= lz_blank_sh_r;
        end
    end

    // Register the display outputs so select and anode move on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit_sel_r  <= 2'd0;
            anode_r      <= 4'b0000;
            frame_tick_r <= 1'b0;
        end else begin
            digit_sel_r  <= digit_sel_nxt_s;
            anode_r      <= anode_nxt_s;
            frame_tick_r <= frame_wrap_s;
        end
    end

    assign digit_sel   = digit_sel_r;
    assign anode       = anode_r;
    assign frame_tick  = frame_tick_r;
    assign blink_phase = blink_phase_r;

    digit_scan_scheduler_chk u_chk (
        .clk        (clk),
        .reset      (reset),
        .anode      (anode_r),
        .frame_tick (frame_tick_r)
    );

endmodule
